// File: rtl/rv32i_types_pkg.sv
// ============================================================================
// rv32i_types_pkg : shared types and reset constants for the fetch stage
// Rev 1.0 -- optional build macro: FETCH_MISALIGN_EN
// ============================================================================
`default_nettype none

package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DEFAULT_RESET_PC  = 32'h0000_0200;
    localparam word_t DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t pc;
        word_t pc4;
        word_t instr;
`ifdef FETCH_MISALIGN_EN
        logic  misaligned;
`endif
    } fetch_ex_pipeline_reg_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// fetch_skid_buffer : one-entry instruction buffer (flush > load > unload)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import rv32i_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  unload,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  valid,
    output word_t instr,
    output word_t pc
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC owner, single-outstanding imem requester, fetch->ex register
// Rev 1.0 -- optional build macro: FETCH_MISALIGN_EN
// ============================================================================
`default_nettype none

module fetch_stage
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC  = DEFAULT_RESET_PC,
    parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        brj_taken,
    input  logic [31:0] brj_addr,
    input  logic        ex_stall,
`ifdef FETCH_MISALIGN_EN
    output logic        fetch_ex_misaligned,
`endif
    output logic        fetch_ex_valid,
    output logic [31:0] fetch_ex_pc,
    output logic [31:0] fetch_ex_pc4,
    output logic [31:0] fetch_ex_instr
);

    localparam word_t C_WORD_MASK = 32'hFFFF_FFFC;

    fetch_state_t           r_state;
    word_t                  r_pc;
    word_t                  r_req_addr;
    fetch_ex_pipeline_reg_t r_fx;

    logic  r_skid_valid;
    word_t r_skid_instr;
    word_t r_skid_pc;

    logic  w_accept;
    logic  w_nofetch;
    word_t w_tgt;
    word_t w_req_next;
    logic  w_fetch_done;
    logic  w_skid_load;
    logic  w_skid_unload;
    logic  w_skid_flush;
    logic  w_new_req;
    word_t w_new_addr;
    logic  w_load;
    word_t w_load_pc;
    word_t w_load_instr;

`ifdef FETCH_MISALIGN_EN
    logic r_mis_pend;
    logic r_idle;
    logic w_mis_load;
    logic w_load_mis;

    // A misaligned target is kept intact so it can be reported as the faulting PC.
    assign w_tgt      = brj_addr;
    assign w_nofetch  = r_mis_pend || r_idle;
    assign w_mis_load = (r_state == FETCH) && r_mis_pend && w_accept;
`else
    assign w_tgt      = brj_addr & C_WORD_MASK;
    assign w_nofetch  = 1'b0;
`endif

    assign w_accept      = !r_fx.valid || !ex_stall;
    assign w_req_next    = r_req_addr + 32'd4;
    assign w_fetch_done  = (r_state == FETCH) && !w_nofetch && !imem_busy;
    assign w_skid_load   = w_fetch_done && !brj_taken && !w_accept;
    assign w_skid_unload = (r_state == HOLD) && !brj_taken && !ex_stall;
    assign w_skid_flush  = (r_state == HOLD) && brj_taken;

    assign imem_ren  = (r_state != HOLD) && !w_nofetch;
    assign imem_addr = r_req_addr & C_WORD_MASK;

    // A new request address is committed only once no response is outstanding.
    always_comb begin
        w_new_req  = 1'b0;
        w_new_addr = w_tgt;
        case (r_state)
            FETCH: w_new_req = brj_taken && (!imem_busy || w_nofetch);
            DRAIN: begin
                w_new_req  = !imem_busy;
                w_new_addr = brj_taken ? w_tgt : r_pc;
            end
            HOLD:  w_new_req = brj_taken;
            default: w_new_req = 1'b0;
        endcase
    end

    always_comb begin
        w_load       = 1'b0;
        w_load_pc    = r_req_addr;
        w_load_instr = imem_rdata;
`ifdef FETCH_MISALIGN_EN
        w_load_mis   = 1'b0;
`endif
        if (w_fetch_done && w_accept) begin
            w_load = 1'b1;
        end else if (w_skid_unload && r_skid_valid) begin
            w_load       = 1'b1;
            w_load_pc    = r_skid_pc;
            w_load_instr = r_skid_instr;
        end
`ifdef FETCH_MISALIGN_EN
        else if (w_mis_load) begin
            w_load       = 1'b1;
            w_load_pc    = r_pc;
            w_load_instr = NOP_INSTR;
            w_load_mis   = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else if (w_new_req) begin
            r_state    <= FETCH;
            r_pc       <= w_new_addr;
            r_req_addr <= w_new_addr;
        end else begin
            case (r_state)
                FETCH: begin
                    if (brj_taken) begin
                        r_pc    <= w_tgt;
                        r_state <= DRAIN;
                    end else if (w_fetch_done) begin
                        r_pc <= w_req_next;
                        if (w_accept) begin
                            r_req_addr <= w_req_next;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                DRAIN: begin
                    if (brj_taken) begin
                        r_pc <= w_tgt;
                    end
                end
                HOLD: begin
                    if (w_skid_unload) begin
                        r_req_addr <= r_pc;
                        r_state    <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_EN
    // After reporting a misaligned target, fetch stays idle until the next redirect.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_mis_pend <= 1'b0;
            r_idle     <= 1'b0;
        end else if (w_new_req) begin
            r_mis_pend <= |w_new_addr[1:0];
            r_idle     <= 1'b0;
        end else if (w_mis_load && !brj_taken) begin
            r_mis_pend <= 1'b0;
            r_idle     <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_fx.valid      <= 1'b0;
            r_fx.pc         <= '0;
            r_fx.pc4        <= '0;
            r_fx.instr      <= NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
            r_fx.misaligned <= 1'b0;
`endif
        end else if (brj_taken) begin
            r_fx.valid      <= 1'b0;
            r_fx.instr      <= NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
            r_fx.misaligned <= 1'b0;
`endif
        end else if (w_load) begin
            r_fx.valid      <= 1'b1;
            r_fx.pc         <= w_load_pc;
            r_fx.pc4        <= w_load_pc + 32'd4;
            r_fx.instr      <= w_load_instr;
`ifdef FETCH_MISALIGN_EN
            r_fx.misaligned <= w_load_mis;
`endif
        end else if (r_fx.valid && !ex_stall) begin
            r_fx.valid      <= 1'b0;
            r_fx.instr      <= NOP_INSTR;
`ifdef FETCH_MISALIGN_EN
            r_fx.misaligned <= 1'b0;
`endif
        end
    end

    fetch_skid_buffer u_skid (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (w_skid_load),
        .unload     (w_skid_unload),
        .flush      (w_skid_flush),
        .load_instr (imem_rdata),
        .load_pc    (r_req_addr),
        .valid      (r_skid_valid),
        .instr      (r_skid_instr),
        .pc         (r_skid_pc)
    );

    assign fetch_ex_valid = r_fx.valid;
    assign fetch_ex_pc    = r_fx.pc;
    assign fetch_ex_pc4   = r_fx.pc4;
    assign fetch_ex_instr = r_fx.instr;
`ifdef FETCH_MISALIGN_EN
    assign fetch_ex_misaligned = r_fx.misaligned;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench; memory returns ~address
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic        brj_taken;
    logic [31:0] brj_addr;
    logic        ex_stall;
    logic        fetch_ex_valid;
    logic [31:0] fetch_ex_pc;
    logic [31:0] fetch_ex_pc4;
    logic [31:0] fetch_ex_instr;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_ex_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign imem_rdata = ~imem_addr;

    fetch_stage dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imem_ren       (imem_ren),
        .imem_addr      (imem_addr),
        .imem_busy      (imem_busy),
        .imem_rdata     (imem_rdata),
        .brj_taken      (brj_taken),
        .brj_addr       (brj_addr),
        .ex_stall       (ex_stall),
`ifdef FETCH_MISALIGN_EN
        .fetch_ex_misaligned (fetch_ex_misaligned),
`endif
        .fetch_ex_valid (fetch_ex_valid),
        .fetch_ex_pc    (fetch_ex_pc),
        .fetch_ex_pc4   (fetch_ex_pc4),
        .fetch_ex_instr (fetch_ex_instr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Leaves the DUT in the first cycle after reset release with idle inputs.
    task automatic rel;
        nRST      = 1'b0;
        imem_busy = 1'b0;
        brj_taken = 1'b0;
        brj_addr  = '0;
        ex_stall  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
    endtask

    initial begin
        nRST      = 1'b0;
        imem_busy = 1'b0;
        brj_taken = 1'b0;
        brj_addr  = '0;
        ex_stall  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", 32'(fetch_ex_valid), 32'h0);
        chk("rst_pc",    fetch_ex_pc,         32'h0);
        chk("rst_pc4",   fetch_ex_pc4,        32'h0);
        chk("rst_instr", fetch_ex_instr,      32'h0000_0013);
        chk("rst_ren",   32'(imem_ren),       32'h1);
        chk("rst_addr",  imem_addr,           32'h0000_0200);

        // zero-wait streaming
        nRST = 1'b1;
        #1;
        chk("s_addr0", imem_addr, 32'h0000_0200);
        tick; #1;
        chk("s_addr1",  imem_addr,           32'h0000_0204);
        chk("s_valid1", 32'(fetch_ex_valid), 32'h1);
        chk("s_pc1",    fetch_ex_pc,         32'h0000_0200);
        chk("s_pc4_1",  fetch_ex_pc4,        32'h0000_0204);
        chk("s_instr1", fetch_ex_instr,      32'hFFFF_FDFF);
        tick; #1;
        chk("s_addr2", imem_addr,   32'h0000_0208);
        chk("s_pc2",   fetch_ex_pc, 32'h0000_0204);

        // redirect while busy: drain stale 0x204 response
        rel();
        tick; imem_busy = 1'b1; brj_taken = 1'b1; brj_addr = 32'h0000_0400; #1;
        chk("d_addr0", imem_addr, 32'h0000_0204);
        tick; brj_taken = 1'b0; #1;
        chk("d_addr1",  imem_addr,           32'h0000_0204);
        chk("d_valid1", 32'(fetch_ex_valid), 32'h0);
        tick; #1;
        chk("d_addr2", imem_addr, 32'h0000_0204);
        tick; imem_busy = 1'b0; #1;
        chk("d_addr3", imem_addr,     32'h0000_0204);
        chk("d_ren3",  32'(imem_ren), 32'h1);
        tick; #1;
        chk("d_next",   imem_addr,           32'h0000_0400);
        chk("d_valid4", 32'(fetch_ex_valid), 32'h0);
        chk("d_instr4", fetch_ex_instr,      32'h0000_0013);
        tick; #1;
        chk("d_pc5",    fetch_ex_pc,         32'h0000_0400);
        chk("d_instr5", fetch_ex_instr,      32'hFFFF_FBFF);

        // stall while 0x208 returns -> skid
        rel();
        tick; #1;
        tick; ex_stall = 1'b1; #1;
        chk("h_addr2", imem_addr, 32'h0000_0208);
        tick; #1;
        chk("h_ren3",   32'(imem_ren),       32'h0);
        chk("h_pc3",    fetch_ex_pc,         32'h0000_0204);
        chk("h_valid3", 32'(fetch_ex_valid), 32'h1);
        tick; ex_stall = 1'b0; #1;
        chk("h_pc4", fetch_ex_pc, 32'h0000_0204);
        tick; #1;
        chk("h_pc5",    fetch_ex_pc,    32'h0000_0208);
        chk("h_instr5", fetch_ex_instr, 32'hFFFF_FDF7);
        chk("h_pc4_5",  fetch_ex_pc4,   32'h0000_020C);
        chk("h_addr5",  imem_addr,      32'h0000_020C);
        tick; #1;
        chk("h_pc6", fetch_ex_pc, 32'h0000_020C);

        // redirect in HOLD drops the skid
        rel();
        tick; #1;
        tick; ex_stall = 1'b1; #1;
        tick; brj_taken = 1'b1; brj_addr = 32'h0000_0100; #1;
        chk("k_ren", 32'(imem_ren), 32'h0);
        tick; brj_taken = 1'b0; ex_stall = 1'b0; #1;
        chk("k_valid", 32'(fetch_ex_valid), 32'h0);
        chk("k_instr", fetch_ex_instr,      32'h0000_0013);
        chk("k_addr",  imem_addr,           32'h0000_0100);
        tick; #1;
        chk("k_pc", fetch_ex_pc, 32'h0000_0100);

        // address wrap
        rel();
        brj_taken = 1'b1; brj_addr = 32'hFFFF_FFFC; #1;
        tick; brj_taken = 1'b0; #1;
        chk("w_addr0", imem_addr, 32'hFFFF_FFFC);
        tick; #1;
        chk("w_addr1", imem_addr,    32'h0000_0000);
        chk("w_pc1",   fetch_ex_pc,  32'hFFFF_FFFC);
        chk("w_pc4_1", fetch_ex_pc4, 32'h0000_0000);
        tick; #1;
        chk("w_pc2",   fetch_ex_pc,  32'h0000_0000);
        chk("w_pc4_2", fetch_ex_pc4, 32'h0000_0004);

        // reset in the middle of a busy request
        rel();
        tick; imem_busy = 1'b1; #1;
        tick; nRST = 1'b0; #1;
        tick; nRST = 1'b1; imem_busy = 1'b0; #1;
        chk("r_addr", imem_addr, 32'h0000_0200);

        // misaligned redirect target
        rel();
        brj_taken = 1'b1; brj_addr = 32'h0000_0402; #1;
`ifdef FETCH_MISALIGN_EN
        tick; brj_taken = 1'b0; #1;
        chk("m_ren0",   32'(imem_ren),       32'h0);
        chk("m_valid0", 32'(fetch_ex_valid), 32'h0);
        tick; #1;
        chk("m_ren1",   32'(imem_ren),            32'h0);
        chk("m_valid1", 32'(fetch_ex_valid),      32'h1);
        chk("m_pc1",    fetch_ex_pc,              32'h0000_0402);
        chk("m_mis1",   32'(fetch_ex_misaligned), 32'h1);
        chk("m_instr1", fetch_ex_instr,           32'h0000_0013);
        tick; #1;
        chk("m_ren2", 32'(imem_ren), 32'h0);
        tick; brj_taken = 1'b1; brj_addr = 32'h0000_0300; #1;
        tick; brj_taken = 1'b0; #1;
        chk("m_ren3",  32'(imem_ren), 32'h1);
        chk("m_addr3", imem_addr,     32'h0000_0300);
`else
        tick; brj_taken = 1'b0; #1;
        chk("m_addr0", imem_addr, 32'h0000_0400);
        tick; #1;
        chk("m_pc1", fetch_ex_pc, 32'h0000_0400);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
